// File: rtl/auto_load_seq_if.sv
// Bundle between the auto-load sequencer and its environment (start logic
// plus serial-PROM read engine).
//
// Handshake: the sequencer pulses EXECUTE for exactly one cycle with AL_ADDR
// valid in that same cycle. The read engine answers by raising BUSY within
// one cycle and holding it while the word is read. Then it drops BUSY to
// signal that the word is finished. AL_DONE is a level from the engine. The
// sequencer clears it by pulsing CLR_AL_DONE once at the start of each
// sequence.
interface auto_load_seq_if #(
  parameter int ADDR_W = 6
);
  logic              START;
  logic              BUSY;
  logic              AL_DONE;
  logic              AL_ENA;
  logic [ADDR_W-1:0] AL_ADDR;
  logic              EXECUTE;
  logic              CLR_AL_DONE;
  logic              COMPLETED;
  logic              ABORTED;
  logic              TMO_ERR;
  logic [3:0]        RETRY_CNT;
  logic [3:0]        DBG_STATE;

  // Sequencer side
  modport master (
    input  START, BUSY, AL_DONE,
    output AL_ENA, AL_ADDR, EXECUTE, CLR_AL_DONE,
           COMPLETED, ABORTED, TMO_ERR, RETRY_CNT, DBG_STATE
  );

  // Start logic / read engine side
  modport slave (
    output START, BUSY, AL_DONE,
    input  AL_ENA, AL_ADDR, EXECUTE, CLR_AL_DONE,
           COMPLETED, ABORTED, TMO_ERR, RETRY_CNT, DBG_STATE
  );
endinterface

// File: rtl/auto_load_seq.sv
// Auto-load sequencer: reads words START_ADDR..MAX_ADDR from the PROM read
// engine, one EXECUTE per word. It retries on a BUSY timeout, checks for an
// early abort, and waits for the final AL_DONE. All outputs are registered
// and decoded from the next state, so they line up with the state they
// describe.
module auto_load_seq #(
  parameter int ADDR_W     = 6,
  parameter int START_ADDR = 0,
  parameter int MAX_ADDR   = 33,
  parameter int TMO_CYC    = 255,
  parameter int MAX_RETRY  = 2,
  parameter int ABORT_ALL  = 0
) (
  input logic             CLK,
  input logic             RST,
  auto_load_seq_if.master bus
);

  localparam int TMO_W    = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);
  localparam int TMO_LAST = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] MAX_A   = ADDR_W'(MAX_ADDR);
  localparam logic [3:0]        RETRY_M = 4'(MAX_RETRY);
  localparam logic [TMO_W-1:0]  TMO_HIT = TMO_W'(TMO_LAST);
  localparam logic [TMO_W-1:0]  TMO_SAT = TMO_W'(TMO_CYC);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CLEAR     = 4'd1,
    S_ISSUE     = 4'd2,
    S_HOLD      = 4'd3,
    S_WAIT_BUSY = 4'd4,
    S_CHECK     = 4'd5,
    S_WAIT_DONE = 4'd6,
    S_FIN_OK    = 4'd7,
    S_FIN_ABORT = 4'd8,
    S_FIN_ERR   = 4'd9
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_addr_inc;
  logic              w_retry_inc;
  logic              w_tmo_hit;
  logic              w_waiting;

  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_retry;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_al_ena;
  logic              r_execute;
  logic              r_clr;
  logic              r_completed;
  logic              r_aborted;
  logic              r_tmo_err;

  // The timeout only counts in the two wait states, and only when timeouts
  // are enabled.
  assign w_tmo_hit = (TMO_CYC != 0) && (r_tmo == TMO_HIT);
  assign w_waiting = (r_state == S_WAIT_BUSY && bus.BUSY) ||
                     (r_state == S_WAIT_DONE && !bus.AL_DONE);

  // Next-state decode plus the datapath strobes for address and retry updates.
  always_comb begin
    w_next      = r_state;
    w_addr_inc  = 1'b0;
    w_retry_inc = 1'b0;
    case (r_state)
      S_IDLE:      if (bus.START) w_next = S_CLEAR;
      S_CLEAR:     w_next = S_ISSUE;
      S_ISSUE:     w_next = S_HOLD;
      S_HOLD:      w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!bus.BUSY) begin
          w_next = S_CHECK;
        end else if (w_tmo_hit) begin
          if (r_retry < RETRY_M) begin
            w_next      = S_ISSUE;
            w_retry_inc = 1'b1;
          end else begin
            w_next = S_FIN_ERR;
          end
        end
      end
      S_CHECK: begin
        // The final word takes priority: AL_DONE here is the normal ending.
        if (r_addr == MAX_A) begin
          w_next = S_WAIT_DONE;
        end else if (bus.AL_DONE && ((ABORT_ALL != 0) || (r_addr == START_A))) begin
          w_next = S_FIN_ABORT;
        end else begin
          w_next     = S_ISSUE;
          w_addr_inc = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (bus.AL_DONE)     w_next = S_FIN_OK;
        else if (w_tmo_hit)  w_next = S_FIN_ERR;
      end
      S_FIN_OK, S_FIN_ABORT, S_FIN_ERR: if (!bus.START) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Address and retry counter; the address holds in Fin states for diagnosis.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr  <= START_A;
      r_retry <= 4'd0;
    end else if (w_next == S_CLEAR) begin
      r_addr  <= START_A;
      r_retry <= 4'd0;
    end else if (w_addr_inc) begin
      r_addr  <= r_addr + 1'b1;
      r_retry <= 4'd0;
    end else if (w_retry_inc) begin
      r_retry <= r_retry + 1'b1;
    end
  end

  // Consecutive-wait counter, saturating, cleared outside the wait states.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tmo <= '0;
    end else if (w_waiting) begin
      if (r_tmo != TMO_SAT) r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  // Moore outputs registered from the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_al_ena    <= 1'b0;
      r_execute   <= 1'b0;
      r_clr       <= 1'b0;
      r_completed <= 1'b0;
      r_aborted   <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_al_ena    <= (w_next != S_IDLE);
      r_execute   <= (w_next == S_ISSUE);
      r_clr       <= (w_next == S_CLEAR);
      r_completed <= (w_next == S_FIN_OK);
      r_aborted   <= (w_next == S_FIN_ABORT);
      r_tmo_err   <= (w_next == S_FIN_ERR);
    end
  end

  assign bus.AL_ENA      = r_al_ena;
  assign bus.AL_ADDR     = r_addr;
  assign bus.EXECUTE     = r_execute;
  assign bus.CLR_AL_DONE = r_clr;
  assign bus.COMPLETED   = r_completed;
  assign bus.ABORTED     = r_aborted;
  assign bus.TMO_ERR     = r_tmo_err;
  assign bus.RETRY_CNT   = r_retry;
  assign bus.DBG_STATE   = r_state;

`ifndef SYNTHESIS
  string w_state_name;
  // Readable state name for waveform viewers.
  always_comb w_state_name = r_state.name();
`endif

endmodule

// File: tb/tb_auto_load_seq.sv
// Directed bench for auto_load_seq with a behavioural PROM read engine.
// DUT0 uses the legacy abort check and DUT1 checks for an abort after every word.
module tb_auto_load_seq;

  logic CLK = 1'b0;
  logic RST;

  auto_load_seq_if #(.ADDR_W(6)) bus0 ();
  auto_load_seq_if #(.ADDR_W(6)) bus1 ();

  auto_load_seq #(
    .ADDR_W(6), .START_ADDR(0), .MAX_ADDR(3), .TMO_CYC(16),
    .MAX_RETRY(2), .ABORT_ALL(0)
  ) u_dut0 (.CLK(CLK), .RST(RST), .bus(bus0));

  auto_load_seq #(
    .ADDR_W(6), .START_ADDR(0), .MAX_ADDR(3), .TMO_CYC(16),
    .MAX_RETRY(2), .ABORT_ALL(1)
  ) u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  // Read-engine knobs, written only by the main initial block.
  int done_addr0  = -1;
  int done_addr1  = -1;
  int stuck_mode  = 0;   // 0 none, 1 stuck once, 2 stuck forever
  int stuck_addr  = 1;

  // Read engine model for DUT0. Each EXECUTE is logged as {RETRY_CNT, AL_ADDR}.
  int         r0_cnt = 0;
  int         r0_exec = 0;
  int         r0_clr = 0;
  int         r0_last = -1;
  bit         r0_stuck_used = 1'b0;
  logic [9:0] r0_log[$];

  always @(negedge CLK) begin
    if (RST) begin
      bus0.BUSY    = 1'b0;
      bus0.AL_DONE = 1'b0;
      r0_cnt       = 0;
    end else begin
      if (bus0.CLR_AL_DONE) begin
        bus0.AL_DONE  = 1'b0;
        bus0.BUSY     = 1'b0;
        r0_cnt        = 0;
        r0_exec       = 0;
        r0_stuck_used = 1'b0;
        r0_log.delete();
        r0_clr++;
      end
      if (bus0.EXECUTE) begin
        r0_exec++;
        r0_log.push_back({bus0.RETRY_CNT, bus0.AL_ADDR});
        r0_last = int'(bus0.AL_ADDR);
        if (stuck_mode == 2 && r0_last == stuck_addr) begin
          r0_cnt = 1000;
        end else if (stuck_mode == 1 && r0_last == stuck_addr && !r0_stuck_used) begin
          r0_cnt = 20;
          r0_stuck_used = 1'b1;
        end else begin
          r0_cnt = 3;
        end
        bus0.BUSY = 1'b1;
      end else if (r0_cnt > 0) begin
        r0_cnt--;
        if (r0_cnt == 0) begin
          bus0.BUSY = 1'b0;
          if (r0_last == done_addr0) bus0.AL_DONE = 1'b1;
        end
      end
    end
  end

  // Read engine model for DUT1: always 3 busy cycles per word.
  int r1_cnt = 0;
  int r1_exec = 0;
  int r1_last = -1;

  always @(negedge CLK) begin
    if (RST) begin
      bus1.BUSY    = 1'b0;
      bus1.AL_DONE = 1'b0;
      r1_cnt       = 0;
    end else begin
      if (bus1.CLR_AL_DONE) begin
        bus1.AL_DONE = 1'b0;
        r1_exec      = 0;
      end
      if (bus1.EXECUTE) begin
        r1_exec++;
        r1_last   = int'(bus1.AL_ADDR);
        r1_cnt    = 3;
        bus1.BUSY = 1'b1;
      end else if (r1_cnt > 0) begin
        r1_cnt--;
        if (r1_cnt == 0) begin
          bus1.BUSY = 1'b0;
          if (r1_last == done_addr1) bus1.AL_DONE = 1'b1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(r0_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < r0_log.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(r0_log[i]), 32'(exp_q[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_flag0(input string tag, input int budget);
    int cyc = 0;
    while (!(bus0.COMPLETED || bus0.ABORTED || bus0.TMO_ERR) && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= budget) check({tag, "_wait_budget"}, 32'(cyc), 32'(budget - 1));
  endtask

  task automatic wait_dbg0(input string tag, input logic [3:0] st, input int min_log, input int budget);
    int cyc = 0;
    while (!(bus0.DBG_STATE == st && r0_log.size() >= min_log) && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= budget) check({tag, "_state_budget"}, 32'(cyc), 32'(budget - 1));
  endtask

  // Drop START and confirm the return to Idle one cycle later.
  task automatic end_seq0(input string tag);
    bus0.START = 1'b0;
    @(negedge CLK);
    check({tag, "_idle_ena"}, 32'(bus0.AL_ENA), 32'd0);
    check({tag, "_idle_flags"}, 32'({bus0.COMPLETED, bus0.ABORTED, bus0.TMO_ERR}), 32'd0);
  endtask

  task automatic check_flags0(input string tag, input logic [2:0] exp_flags);
    check({tag, "_flags"}, 32'({bus0.COMPLETED, bus0.ABORTED, bus0.TMO_ERR}), 32'(exp_flags));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int clr_before;
    int cyc;
    bit seen_c;

    RST        = 1'b1;
    bus0.START = 1'b0;
    bus1.START = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_ena",   32'(bus0.AL_ENA), 32'd0);
    check("rst_exec",  32'(bus0.EXECUTE), 32'd0);
    check("rst_clr",   32'(bus0.CLR_AL_DONE), 32'd0);
    check_flags0("rst", 3'b000);
    check("rst_addr",  32'(bus0.AL_ADDR), 32'd0);
    check("rst_retry", 32'(bus0.RETRY_CNT), 32'd0);
    check("rst_ena1",  32'(bus1.AL_ENA), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Nominal run, AL_DONE after the last word
    done_addr0 = 3;
    clr_before = r0_clr;
    bus0.START = 1'b1;
    wait_flag0("nom", 300);
    check_flags0("nom", 3'b100);
    check("nom_exec", 32'(r0_exec), 32'd4);
    check("nom_clr",  32'(r0_clr - clr_before), 32'd1);
    check("nom_addr", 32'(bus0.AL_ADDR), 32'd3);
    exp_q = '{10'h000, 10'h001, 10'h002, 10'h003};
    check_log("nom");
    repeat (3) @(negedge CLK);
    check("nom_hold_completed", 32'(bus0.COMPLETED), 32'd1);
    end_seq0("nom");

    // Legacy abort: AL_DONE after word 0
    done_addr0 = 0;
    bus0.START = 1'b1;
    wait_flag0("abt0", 300);
    check_flags0("abt0", 3'b010);
    check("abt0_exec", 32'(r0_exec), 32'd1);
    check("abt0_addr", 32'(bus0.AL_ADDR), 32'd0);
    end_seq0("abt0");

    // Legacy mode: AL_DONE after word 1 is not an abort
    done_addr0 = 1;
    bus0.START = 1'b1;
    wait_flag0("abt1", 300);
    check_flags0("abt1", 3'b100);
    check("abt1_exec", 32'(r0_exec), 32'd4);
    end_seq0("abt1");

    // ABORT_ALL=1: AL_DONE after word 2 aborts
    done_addr1 = 2;
    bus1.START = 1'b1;
    cyc = 0;
    while (!(bus1.COMPLETED || bus1.ABORTED || bus1.TMO_ERR) && cyc < 300) begin
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= 300) check("all_wait_budget", 32'(cyc), 32'd299);
    check("all_flags", 32'({bus1.COMPLETED, bus1.ABORTED, bus1.TMO_ERR}), 32'b010);
    check("all_exec", 32'(r1_exec), 32'd3);
    check("all_addr", 32'(bus1.AL_ADDR), 32'd2);
    bus1.START = 1'b0;
    @(negedge CLK);
    check("all_idle_ena", 32'(bus1.AL_ENA), 32'd0);

    // BUSY stuck once on word 1: one retry, then completion
    done_addr0 = 3;
    stuck_mode = 1;
    bus0.START = 1'b1;
    wait_flag0("rty", 400);
    check_flags0("rty", 3'b100);
    check("rty_exec", 32'(r0_exec), 32'd5);
    check("rty_retry_end", 32'(bus0.RETRY_CNT), 32'd0);
    exp_q = '{10'h000, 10'h001, 10'h041, 10'h002, 10'h003};
    check_log("rty");
    end_seq0("rty");

    // BUSY stuck forever on word 1: retries exhausted
    stuck_mode = 2;
    bus0.START = 1'b1;
    wait_flag0("stk", 400);
    check_flags0("stk", 3'b001);
    check("stk_addr",  32'(bus0.AL_ADDR), 32'd1);
    check("stk_retry", 32'(bus0.RETRY_CNT), 32'd2);
    exp_q = '{10'h000, 10'h001, 10'h041, 10'h081};
    check_log("stk");
    end_seq0("stk");
    stuck_mode = 0;

    // AL_DONE never arrives: Wait_Done timeout after 16 cycles
    done_addr0 = -1;
    bus0.START = 1'b1;
    wait_dbg0("wd", 4'd6, 4, 300);
    cyc = 0;
    seen_c = 1'b0;
    while (!bus0.TMO_ERR && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (bus0.COMPLETED) seen_c = 1'b1;
    end
    check("wd_tmo_cycles", 32'(cyc), 32'd16);
    check("wd_no_completed", 32'(seen_c), 32'd0);
    check_flags0("wd", 3'b001);
    check("wd_addr", 32'(bus0.AL_ADDR), 32'd3);
    end_seq0("wd");

    // START dropped mid-sequence is ignored until the Fin state
    done_addr0 = 3;
    bus0.START = 1'b1;
    repeat (3) @(negedge CLK);
    bus0.START = 1'b0;
    wait_flag0("sdrop", 300);
    check_flags0("sdrop", 3'b100);
    check("sdrop_exec", 32'(r0_exec), 32'd4);
    @(negedge CLK);
    check("sdrop_idle_ena", 32'(bus0.AL_ENA), 32'd0);

    // Asynchronous reset in Wait_Busy on word 2
    bus0.START = 1'b1;
    wait_dbg0("rmid", 4'd4, 3, 300);
    #2 RST = 1'b1;
    #1;
    check("rmid_ena",  32'(bus0.AL_ENA), 32'd0);
    check("rmid_exec", 32'(bus0.EXECUTE), 32'd0);
    check_flags0("rmid", 3'b000);
    check("rmid_addr", 32'(bus0.AL_ADDR), 32'd0);
    check("rmid_retry", 32'(bus0.RETRY_CNT), 32'd0);
    bus0.START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_flags0("rmid_after", 3'b000);
    bus0.START = 1'b1;
    wait_flag0("rnew", 300);
    check_flags0("rnew", 3'b100);
    check("rnew_exec", 32'(r0_exec), 32'd4);
    exp_q = '{10'h000, 10'h001, 10'h002, 10'h003};
    check_log("rnew");
    end_seq0("rnew");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
